nes_run_ctrl: RTL and testbench

- Upstream pacing and run-control stage for nes_clocks.
- Generates the master `en` strobe and the synchronous `rst_master` that nes_clocks consumes.
- Throttles the host clock down to the NES master rate with a fractional accumulator.
- Provides run, pause, single-CPU-cycle step and single-frame step for the debug UI, always stopping on a CPU-cycle boundary (24 en pulses).

---
 rtl/nes_run_ctrl_if.sv | 25 ++
 rtl/nes_run_ctrl.sv | 157 +++++++++++++++
 tb/tb_nes_run_ctrl.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_run_ctrl_if.sv
// Run-control bus between the debug UI / PPU side and nes_run_ctrl.
// The master drives requests; the slave returns the pacing strobe and status.
interface nes_run_ctrl_if;
    logic        run_req;
    logic        step_cpu;
    logic        step_frame;
    logic        frame_start;
    logic        soft_reset;
    logic        turbo;
    logic        en;
    logic        rst_master;
    logic        paused;
    logic [4:0]  phase;
    logic [31:0] cpu_cycles;

    modport master (
        output run_req, step_cpu, step_frame, frame_start, soft_reset, turbo,
        input  en, rst_master, paused, phase, cpu_cycles
    );

    modport slave (
        input  run_req, step_cpu, step_frame, frame_start, soft_reset, turbo,
        output en, rst_master, paused, phase, cpu_cycles
    );
endinterface

// File: rtl/nes_run_ctrl.sv
// Paces the NES master-clock enable from the host clock and implements run, pause,
// CPU-cycle step and frame step, always stopping on a 24-pulse CPU-cycle boundary.
module nes_run_ctrl #(
    parameter int unsigned ACC_W    = 24,
    parameter int unsigned INC      = 3603288,
    parameter int unsigned RST_HOLD = 16
) (
    input logic           clk_master,
    input logic           rst_master_n,
    nes_run_ctrl_if.slave ctrl
);
    typedef enum logic [2:0] {
        StReset,
        StRun,
        StPausing,
        StPaused,
        StStepCpu,
        StStepFrame
    } state_e;

    localparam int unsigned   HoldW      = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HoldW-1:0] HoldReload = HoldW'(RST_HOLD - 1);
    localparam logic [ACC_W-1:0] IncVal     = ACC_W'(INC);

    state_e            state_q;
    logic [HoldW-1:0]  hold_q;
    logic [ACC_W-1:0]  acc_q;
    logic              en_q;
    logic              rst_q;
    logic              paused_q;
    logic [4:0]        phase_q;
    logic [31:0]       cpu_q;
    logic              frame_seen_q;

    logic [ACC_W:0]    acc_sum;
    logic              tick;
    logic              gate;
    logic              issue;
    logic              boundary;
    logic [4:0]        phase_inc;

    always_comb begin
        acc_sum   = {1'b0, acc_q} + {1'b0, IncVal};
        tick      = acc_sum[ACC_W] | ctrl.turbo;
        gate      = state_q inside {StRun, StPausing, StStepCpu, StStepFrame};
        issue     = tick & gate;
        boundary  = issue && (phase_q == 5'd23);
        phase_inc = (phase_q == 5'd23) ? 5'd0 : phase_q + 5'd1;
    end

    always_ff @(posedge clk_master or negedge rst_master_n) begin
        if (!rst_master_n) begin
            state_q      <= StReset;
            hold_q       <= HoldReload;
            acc_q        <= '0;
            en_q         <= 1'b0;
            rst_q        <= 1'b1;
            paused_q     <= 1'b0;
            phase_q      <= 5'd0;
            cpu_q        <= 32'd0;
            frame_seen_q <= 1'b0;
        end else if (ctrl.soft_reset) begin
            state_q      <= StReset;
            hold_q       <= HoldReload;
            acc_q        <= '0;
            en_q         <= 1'b0;
            rst_q        <= 1'b1;
            paused_q     <= 1'b0;
            phase_q      <= 5'd0;
            cpu_q        <= 32'd0;
            frame_seen_q <= 1'b0;
        end else begin
            acc_q <= (state_q == StReset) ? '0 : acc_sum[ACC_W-1:0];
            en_q  <= issue;
            if (issue) begin
                phase_q <= phase_inc;
                if (boundary) begin
                    cpu_q <= cpu_q + 32'd1;
                end
            end

            case (state_q)
                StReset: begin
                    if (hold_q == '0) begin
                        rst_q   <= 1'b0;
                        phase_q <= 5'd0;
                        if (ctrl.run_req) begin
                            state_q <= StRun;
                        end else begin
                            state_q  <= StPaused;
                            paused_q <= 1'b1;
                        end
                    end else begin
                        hold_q <= hold_q - HoldW'(1);
                    end
                end
                StRun: begin
                    // Already on a boundary after this edge: nothing left to drain.
                    if (!ctrl.run_req) begin
                        if ((issue ? phase_inc : phase_q) == 5'd0) begin
                            state_q  <= StPaused;
                            paused_q <= 1'b1;
                        end else begin
                            state_q <= StPausing;
                        end
                    end
                end
                StPausing: begin
                    if (ctrl.run_req) begin
                        state_q <= StRun;
                    end else if (boundary) begin
                        state_q  <= StPaused;
                        paused_q <= 1'b1;
                    end
                end
                StPaused: begin
                    if (ctrl.run_req) begin
                        state_q  <= StRun;
                        paused_q <= 1'b0;
                    end else if (ctrl.step_frame) begin
                        state_q      <= StStepFrame;
                        paused_q     <= 1'b0;
                        frame_seen_q <= ctrl.frame_start;
                    end else if (ctrl.step_cpu) begin
                        state_q  <= StStepCpu;
                        paused_q <= 1'b0;
                    end
                end
                StStepCpu: begin
                    if (boundary) begin
                        state_q  <= StPaused;
                        paused_q <= 1'b1;
                    end
                end
                StStepFrame: begin
                    // A frame_start coincident with the boundary pulse still ends the step.
                    if ((frame_seen_q || ctrl.frame_start) && boundary) begin
                        state_q      <= StPaused;
                        paused_q     <= 1'b1;
                        frame_seen_q <= 1'b0;
                    end else if (ctrl.frame_start) begin
                        frame_seen_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StReset;
                end
            endcase
        end
    end

    assign ctrl.en         = en_q;
    assign ctrl.rst_master = rst_q;
    assign ctrl.paused     = paused_q;
    assign ctrl.phase      = phase_q;
    assign ctrl.cpu_cycles = cpu_q;
endmodule

// File: tb/tb_nes_run_ctrl.sv
// Scoreboard bench for nes_run_ctrl: stimulus queues expected reset-end and pause
// events; a monitor process pops and compares them as the DUT presents them.
module tb_nes_run_ctrl;
    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    nes_run_ctrl_if bus ();

    nes_run_ctrl u_dut (
        .clk_master   (clk),
        .rst_master_n (rst_n),
        .ctrl         (bus)
    );

    // kind 0: rst_master falls, cnt = cycles held high; kind 1: paused rises, cnt = en pulses.
    typedef struct {
        int kind;
        int cnt;
        int phase;
        int cpu;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks     = 0;
    int   n_errors     = 0;
    int   n_events     = 0;
    int   hi_cnt       = 0;
    int   en_since_evt = 0;
    logic rst_prev     = 1'b1;
    logic paused_prev  = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_rng(input string name, input longint act, input longint lo,
                           input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic handle_event(input int kind, input int cnt);
        exp_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: got kind %0d cnt %0d expected no event", kind, cnt);
        end else begin
            e = sb_q.pop_front();
            chk("event_kind", kind, e.kind);
            if (kind == 0) chk("rst_hold_cycles", cnt, e.cnt);
            else           chk("en_pulses_to_pause", cnt, e.cnt);
            chk("event_phase", bus.phase, e.phase);
            chk("event_cpu_cycles", bus.cpu_cycles, e.cpu);
        end
        n_events++;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hi_cnt = 0;
            end else begin
                if (bus.rst_master) hi_cnt++;
                if (bus.en) en_since_evt++;
                if (bus.en && bus.rst_master) chk("en_while_rst_master", 1, 0);
                if (rst_prev && !bus.rst_master) begin
                    handle_event(0, hi_cnt);
                    hi_cnt       = 0;
                    en_since_evt = 0;
                end
                if (!paused_prev && bus.paused) begin
                    handle_event(1, en_since_evt);
                    en_since_evt = 0;
                end
            end
            rst_prev    = bus.rst_master;
            paused_prev = bus.paused;
        end
    end

    task automatic sample();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_events(input int target, input int budget, input string name);
        int c = 0;
        while (n_events < target && c < budget) begin
            sample();
            c++;
        end
        chk(name, n_events >= target, 1);
    endtask

    task automatic push(input int kind, input int cnt, input int phase, input int cpu);
        exp_t e;
        e.kind  = kind;
        e.cnt   = cnt;
        e.phase = phase;
        e.cpu   = cpu;
        sb_q.push_back(e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        int cnt;
        int consec;
        logic prev;

        rst_n            = 1'b0;
        bus.run_req      = 1'b1;
        bus.turbo        = 1'b1;
        bus.step_cpu     = 1'b0;
        bus.step_frame   = 1'b0;
        bus.frame_start  = 1'b0;
        bus.soft_reset   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_rst_master", bus.rst_master, 1);
        chk("reset_en", bus.en, 0);
        chk("reset_paused", bus.paused, 0);

        // Turbo free-run from reset: en every cycle, 48 pulses = 2 CPU cycles.
        push(0, 16, 0, 0);
        rst_n = 1'b1;
        wait_events(1, 40, "wait_reset_end");
        cyc = 0;
        while (en_since_evt < 48 && cyc < 200) begin
            sample();
            cyc++;
        end
        chk("turbo_cycles_for_48_pulses", cyc, 48);
        chk("turbo_phase_after_48", bus.phase, 0);
        chk("turbo_cpu_after_48", bus.cpu_cycles, 2);

        // Drop run_req at phase 5: 53 pulses so far plus 19 drain = 72.
        cyc = 0;
        while (bus.phase != 5'd5 && cyc < 100) begin
            sample();
            cyc++;
        end
        push(1, 72, 0, 3);
        bus.run_req = 1'b0;
        wait_events(2, 100, "wait_pause_after_run");

        // Single CPU step; a second step_cpu during the step has no effect.
        push(1, 24, 0, 4);
        bus.step_cpu = 1'b1;
        sample();
        bus.step_cpu = 1'b0;
        repeat (5) sample();
        bus.step_cpu = 1'b1;
        sample();
        bus.step_cpu = 1'b0;
        wait_events(3, 100, "wait_pause_after_step_cpu");
        repeat (10) sample();
        chk("idle_en_after_step_cpu", en_since_evt, 0);
        chk("idle_paused_after_step_cpu", bus.paused, 1);

        // Frame step: frame_start at pulse 100 runs on to boundary 120 (+5 CPU cycles).
        push(1, 120, 0, 9);
        bus.step_frame = 1'b1;
        sample();
        bus.step_frame = 1'b0;
        cyc = 0;
        while (en_since_evt < 100 && cyc < 300) begin
            sample();
            cyc++;
        end
        bus.frame_start = 1'b1;
        sample();
        bus.frame_start = 1'b0;
        wait_events(4, 100, "wait_pause_after_step_frame");

        // soft_reset mid frame step at phase 13.
        push(0, 16, 0, 0);
        bus.step_frame = 1'b1;
        sample();
        bus.step_frame = 1'b0;
        cyc = 0;
        while (bus.phase != 5'd13 && cyc < 100) begin
            sample();
            cyc++;
        end
        bus.soft_reset = 1'b1;
        sample();
        bus.soft_reset = 1'b0;
        chk("soft_reset_en_drop", bus.en, 0);
        chk("soft_reset_rst_master", bus.rst_master, 1);
        bus.run_req = 1'b1;
        wait_events(5, 40, "wait_soft_reset_end");

        // Async reset mid-run: outputs return to reset values without a clock edge.
        repeat (30) sample();
        chk("pre_async_cpu_nonzero", bus.cpu_cycles != 0, 1);
        rst_n = 1'b0;
        #1;
        chk("async_en", bus.en, 0);
        chk("async_rst_master", bus.rst_master, 1);
        chk("async_paused", bus.paused, 0);
        chk("async_phase", bus.phase, 0);
        chk("async_cpu_cycles", bus.cpu_cycles, 0);
        push(0, 16, 0, 0);
        bus.turbo = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_events(6, 40, "wait_async_reset_end");

        // Throttled: 50000 * 3603288 / 2^24 = 10738.64 pulses in any 50000-cycle window.
        repeat (10) sample();
        cnt    = 0;
        consec = 0;
        prev   = 1'b0;
        for (int i = 0; i < 50000; i++) begin
            sample();
            if (bus.en) begin
                cnt++;
                if (prev) consec++;
            end
            prev = bus.en;
        end
        chk_rng("throttle_en_count", cnt, 10738, 10739);
        chk("throttle_no_back_to_back", consec, 0);
        chk("throttle_phase", bus.phase, en_since_evt % 24);
        chk("throttle_cpu_cycles", bus.cpu_cycles, en_since_evt / 24);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
